// File: rtl/spi_pwm_pkg.sv
// Shared state encoding and frame constants for the SPI PWM configuration link.
package spi_pwm_pkg;

  localparam int unsigned DEFAULT_CLOCK_DIV_WIDTH  = 32;
  localparam int unsigned DEFAULT_DUTY_CYCLE_WIDTH = 8;
  localparam int unsigned FRAME_WIDTH = DEFAULT_CLOCK_DIV_WIDTH + DEFAULT_DUTY_CYCLE_WIDTH;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_CS_SETUP   = 3'd1,
    ST_SHIFT_HIGH = 3'd2,
    ST_SHIFT_LOW  = 3'd3,
    ST_CS_HOLD    = 3'd4,
    ST_CS_GAP     = 3'd5
  } spi_master_state_t;

  function automatic int unsigned frame_width(input int unsigned div_w, input int unsigned duty_w);
    return div_w + duty_w;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs into the clk domain.
module sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // Metastability filter: first stage may go metastable, second stage is used
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/spi_pwm_master.sv
// Mode-0, LSB-first SPI master that sends one {duty, clk_div} frame per start
// and flags any bit where the slave's MISO echo disagrees with MOSI.
module spi_pwm_master
  import spi_pwm_pkg::*;
#(
  parameter int unsigned SCLK_HALF_DIV    = 4,
  parameter int unsigned CLOCK_DIV_WIDTH  = DEFAULT_CLOCK_DIV_WIDTH,
  parameter int unsigned DUTY_CYCLE_WIDTH = DEFAULT_DUTY_CYCLE_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [CLOCK_DIV_WIDTH-1:0]  clk_div_in,
  input  logic [DUTY_CYCLE_WIDTH-1:0] duty_in,
  output logic                        busy,
  output logic                        done,
  output logic                        loopback_err,
  output logic                        spi_sclk,
  output logic                        spi_mosi,
  output logic                        spi_cs,
  input  logic                        spi_miso
);

  localparam int unsigned FW = frame_width(CLOCK_DIV_WIDTH, DUTY_CYCLE_WIDTH);
  localparam int unsigned HW = $clog2(SCLK_HALF_DIV + 1);
  localparam int unsigned BW = $clog2(FW);
  localparam logic [HW-1:0] HALF_LAST = HW'(SCLK_HALF_DIV - 1);
  localparam logic [HW-1:0] HALF_INC  = HW'(1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(FW - 1);
  localparam logic [BW-1:0] BIT_INC   = BW'(1);

  if (SCLK_HALF_DIV < 2) begin : g_half_div_check
    $error("SCLK_HALF_DIV must be at least 2");
  end

  spi_master_state_t state_q;
  logic [HW-1:0]     half_q;
  logic [BW-1:0]     bit_q;
  logic [FW-2:0]     shreg_q;
  logic              cs_q;
  logic              sclk_q;
  logic              mosi_q;
  logic              busy_q;
  logic              done_q;
  logic              lb_err_q;
  logic              flag_q;

  logic [FW-1:0]     frame_s;
  logic              half_last_s;
  logic              miso_sync_s;

  assign frame_s     = {duty_in, clk_div_in};
  assign half_last_s = (half_q == HALF_LAST);

  sync_2ff #(.WIDTH(1)) u_miso_sync (
    .clk_i  (clk),
    .rst_ni (rst),
    .d_i    (spi_miso),
    .q_o    (miso_sync_s)
  );

  // Frame sequencer: phase timing, bit shifting and loopback tracking.
  // shreg_q holds the bits still to be sent after the one on MOSI.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      half_q   <= '0;
      bit_q    <= '0;
      shreg_q  <= '0;
      cs_q     <= 1'b1;
      sclk_q   <= 1'b0;
      mosi_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      lb_err_q <= 1'b0;
      flag_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          half_q <= '0;
          bit_q  <= '0;
          if (start) begin
            state_q <= ST_CS_SETUP;
            shreg_q <= frame_s[FW-1:1];
            mosi_q  <= frame_s[0];
            cs_q    <= 1'b0;
            busy_q  <= 1'b1;
            flag_q  <= 1'b0;
          end
        end
        ST_CS_SETUP: begin
          if (half_last_s) begin
            half_q  <= '0;
            sclk_q  <= 1'b1;
            state_q <= ST_SHIFT_HIGH;
          end else begin
            half_q <= half_q + HALF_INC;
          end
        end
        ST_SHIFT_HIGH: begin
          if (half_last_s) begin
            half_q <= '0;
            sclk_q <= 1'b0;
            // Synchronizer delay is covered: the echo of this bit has been stable >= 2 cycles
            if (miso_sync_s != mosi_q) begin
              flag_q <= 1'b1;
            end
            if (bit_q == BIT_LAST) begin
              state_q <= ST_CS_HOLD;
            end else begin
              state_q <= ST_SHIFT_LOW;
              mosi_q  <= shreg_q[0];
              shreg_q <= {1'b0, shreg_q[FW-2:1]};
              bit_q   <= bit_q + BIT_INC;
            end
          end else begin
            half_q <= half_q + HALF_INC;
          end
        end
        ST_SHIFT_LOW: begin
          if (half_last_s) begin
            half_q  <= '0;
            sclk_q  <= 1'b1;
            state_q <= ST_SHIFT_HIGH;
          end else begin
            half_q <= half_q + HALF_INC;
          end
        end
        ST_CS_HOLD: begin
          if (half_last_s) begin
            half_q   <= '0;
            cs_q     <= 1'b1;
            mosi_q   <= 1'b0;
            done_q   <= 1'b1;
            lb_err_q <= flag_q;
            state_q  <= ST_CS_GAP;
          end else begin
            half_q <= half_q + HALF_INC;
          end
        end
        ST_CS_GAP: begin
          if (half_last_s) begin
            half_q  <= '0;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            half_q <= half_q + HALF_INC;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          half_q  <= '0;
          cs_q    <= 1'b1;
          sclk_q  <= 1'b0;
          mosi_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign loopback_err = lb_err_q;
  assign spi_sclk     = sclk_q;
  assign spi_mosi     = mosi_q;
  assign spi_cs       = cs_q;

endmodule

// File: tb/tb_spi_pwm_master.sv
// Self-checking bench for spi_pwm_master: a bus monitor plays the slave, and
// expectations come from the frame/timing rules (81H, 82H, H+1, 40 bits).
module tb_spi_pwm_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        start, sel, miso_tie0;
  logic [31:0] clk_div_in;
  logic [7:0]  duty_in;
  logic        start4, start2;
  logic        busy4, done4, lb4, sclk4, mosi4, cs4, miso4;
  logic        busy2, done2, lb2, sclk2, mosi2, cs2, miso2;
  logic        obs_busy, obs_done, obs_lb, obs_sclk, obs_mosi, obs_cs;

  int checks = 0;
  int errors = 0;

  assign start4 = start & ~sel;
  assign start2 = start & sel;
  assign miso4  = miso_tie0 ? 1'b0 : mosi4;
  assign miso2  = miso_tie0 ? 1'b0 : mosi2;

  spi_pwm_master #(.SCLK_HALF_DIV(4), .CLOCK_DIV_WIDTH(32), .DUTY_CYCLE_WIDTH(8)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .clk_div_in(clk_div_in), .duty_in(duty_in),
    .busy(busy4), .done(done4), .loopback_err(lb4), .spi_sclk(sclk4), .spi_mosi(mosi4),
    .spi_cs(cs4), .spi_miso(miso4));

  spi_pwm_master #(.SCLK_HALF_DIV(2), .CLOCK_DIV_WIDTH(32), .DUTY_CYCLE_WIDTH(8)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .clk_div_in(clk_div_in), .duty_in(duty_in),
    .busy(busy2), .done(done2), .loopback_err(lb2), .spi_sclk(sclk2), .spi_mosi(mosi2),
    .spi_cs(cs2), .spi_miso(miso2));

  assign obs_busy = sel ? busy2 : busy4;
  assign obs_done = sel ? done2 : done4;
  assign obs_lb   = sel ? lb2   : lb4;
  assign obs_sclk = sel ? sclk2 : sclk4;
  assign obs_mosi = sel ? mosi2 : mosi4;
  assign obs_cs   = sel ? cs2   : cs4;

  // Slave-side monitor: bits captured at SCLK rises, run lengths of CS/busy
  logic [63:0] cur_bits = '0, last_bits = '0;
  int cur_n = 0, last_n = 0, frames_seen = 0;
  int cs_run = 0, last_cs_low = 0, gap_run = 0, last_gap = 0;
  int busy_run = 0, last_busy = 0, busy_falls = 0;
  int done_cnt = 0, done_wide = 0;
  logic last_lb = 1'b0;
  logic prev_sclk = 1'b0, prev_cs = 1'b1, prev_busy = 1'b0, prev_done = 1'b0;

  always @(negedge clk) begin
    prev_sclk <= obs_sclk;
    prev_cs   <= obs_cs;
    prev_busy <= obs_busy;
    prev_done <= obs_done;
    if (obs_sclk && !prev_sclk && cur_n < 64) begin
      cur_bits[cur_n] <= obs_mosi;
      cur_n <= cur_n + 1;
    end
    if (!obs_cs) cs_run <= cs_run + 1;
    else gap_run <= gap_run + 1;
    if (obs_cs && !prev_cs) begin
      frames_seen <= frames_seen + 1;
      last_bits   <= cur_bits;
      last_n      <= cur_n;
      last_cs_low <= cs_run;
      cur_bits    <= '0;
      cur_n       <= 0;
      cs_run      <= 0;
      gap_run     <= 1;
    end
    if (!obs_cs && prev_cs) begin
      last_gap <= gap_run;
      cs_run   <= 1;
    end
    if (obs_busy) busy_run <= busy_run + 1;
    if (!obs_busy && prev_busy) begin
      last_busy  <= busy_run;
      busy_falls <= busy_falls + 1;
      busy_run   <= 0;
    end
    if (obs_done) begin
      done_cnt <= done_cnt + 1;
      last_lb  <= obs_lb;
      if (prev_done) done_wide <= done_wide + 1;
    end
  end

  function automatic logic [39:0] rand_frame();
    logic [31:0] a;
    logic [31:0] b;
    a = $urandom;
    b = $urandom;
    return {b[7:0], a};
  endfunction

  task automatic wait_busy_falls(input int target, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      if (busy_falls >= target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic pulse_start(input logic [39:0] fr);
    @(posedge clk); #1;
    clk_div_in = fr[31:0];
    duty_in    = fr[39:32];
    start      = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_frame(input logic [39:0] fr, output bit ok);
    int b0;
    b0 = busy_falls;
    pulse_start(fr);
    wait_busy_falls(b0 + 1, ok);
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if (cs4 !== 1'b1 || sclk4 !== 1'b0 || mosi4 !== 1'b0 || busy4 !== 1'b0 || done4 !== 1'b0 || lb4 !== 1'b0) begin
      errors++;
      $display("FAIL reset_h4: cs=%b sclk=%b mosi=%b busy=%b done=%b lb=%b expected 1 0 0 0 0 0",
               cs4, sclk4, mosi4, busy4, done4, lb4);
    end
    checks++;
    if (cs2 !== 1'b1 || sclk2 !== 1'b0 || busy2 !== 1'b0) begin
      errors++;
      $display("FAIL reset_h2: cs=%b sclk=%b busy=%b expected 1 0 0", cs2, sclk2, busy2);
    end
    @(negedge clk); #1;
    rst = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (obs_cs !== 1'b1 || obs_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: cs=%b busy=%b expected cs=1 busy=0", obs_cs, obs_busy);
    end
  endtask

  task automatic test_basic();
    logic [39:0] fr;
    bit ok;
    int d0, w0, b0;
    sel = 1'b0; miso_tie0 = 1'b0;
    fr = {8'h80, 32'h0000_0011};
    d0 = done_cnt; w0 = done_wide; b0 = busy_falls;
    pulse_start(fr);
    checks++;
    if (obs_busy !== 1'b1 || obs_cs !== 1'b0 || obs_mosi !== fr[0]) begin
      errors++;
      $display("FAIL basic_entry: busy=%b cs=%b mosi=%b expected busy=1 cs=0 mosi=%b", obs_busy, obs_cs, obs_mosi, fr[0]);
    end
    wait_busy_falls(b0 + 1, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL basic_timeout: frame did not complete"); end
    checks++;
    if (last_n !== 40) begin errors++; $display("FAIL basic_sclk_rises: got %0d expected 40", last_n); end
    checks++;
    if (last_bits[39:0] !== fr) begin errors++; $display("FAIL basic_bits: got %h expected %h", last_bits[39:0], fr); end
    checks++;
    if (last_bits[31:0] !== 32'd17) begin errors++; $display("FAIL basic_slave_div: got %0d expected 17", last_bits[31:0]); end
    checks++;
    if (last_bits[39:32] !== 8'd128) begin errors++; $display("FAIL basic_slave_duty: got %0d expected 128", last_bits[39:32]); end
    checks++;
    if (last_cs_low !== 324) begin errors++; $display("FAIL basic_cs_low: got %0d expected 324", last_cs_low); end
    checks++;
    if (last_busy !== 328) begin errors++; $display("FAIL basic_busy_len: got %0d expected 328", last_busy); end
    checks++;
    if (done_cnt - d0 !== 1 || done_wide !== w0) begin
      errors++;
      $display("FAIL basic_done: pulses=%0d wide=%0d expected 1 pulse of one cycle", done_cnt - d0, done_wide - w0);
    end
    checks++;
    if (last_lb !== 1'b0) begin errors++; $display("FAIL basic_lb: got %b expected 0", last_lb); end
  endtask

  task automatic test_loopback();
    logic [39:0] fr [3];
    logic        tie [3];
    bit ok;
    int d0;
    sel = 1'b0;
    fr[0] = 40'hFF_FFFF_FFFF; tie[0] = 1'b1;
    fr[1] = rand_frame();     tie[1] = 1'b0;
    fr[2] = 40'h0;            tie[2] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      miso_tie0 = tie[i];
      d0 = done_cnt;
      run_frame(fr[i], ok);
      checks++;
      if (!ok || done_cnt - d0 !== 1 || last_lb !== (tie[i] && (fr[i] != 40'h0))) begin
        errors++;
        $display("FAIL loopback_%0d: done_pulses=%0d lb=%b expected 1 pulse lb=%b",
                 i, done_cnt - d0, last_lb, tie[i] && (fr[i] != 40'h0));
      end
      if (i == 0) begin
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (obs_lb !== 1'b1) begin errors++; $display("FAIL loopback_hold: got %b expected 1", obs_lb); end
      end
    end
    miso_tie0 = 1'b0;
  endtask

  task automatic test_busy_ignore();
    logic [39:0] fr1, fr2;
    bit ok;
    int f0, b0;
    sel = 1'b0; miso_tie0 = 1'b0;
    fr1 = rand_frame();
    fr2 = {8'h01, fr1[31:0]};
    if (fr1[39:32] == 8'h01) fr1[39:32] = 8'h02;
    f0 = frames_seen; b0 = busy_falls;
    pulse_start(fr1);
    repeat (100) @(posedge clk);
    #1;
    pulse_start(fr2);
    wait_busy_falls(b0 + 1, ok);
    repeat (20) @(posedge clk);
    #1;
    checks++;
    if (!ok || frames_seen - f0 !== 1 || obs_busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_ignore_count: frames=%0d busy=%b expected 1 frame and idle", frames_seen - f0, obs_busy);
    end
    checks++;
    if (last_bits[39:0] !== fr1) begin errors++; $display("FAIL busy_ignore_data: got %h expected %h", last_bits[39:0], fr1); end
    run_frame(fr2, ok);
    checks++;
    if (!ok || frames_seen - f0 !== 2 || last_bits[39:0] !== fr2) begin
      errors++;
      $display("FAIL busy_ignore_next: frames=%0d bits=%h expected 2 frames bits=%h", frames_seen - f0, last_bits[39:0], fr2);
    end
  endtask

  task automatic test_midframe_change();
    logic [39:0] fr, other;
    bit ok;
    int b0;
    sel = 1'b0; miso_tie0 = 1'b0;
    fr = rand_frame();
    other = ~fr;
    b0 = busy_falls;
    pulse_start(fr);
    repeat (150) @(posedge clk);
    #1;
    clk_div_in = other[31:0];
    duty_in    = other[39:32];
    wait_busy_falls(b0 + 1, ok);
    checks++;
    if (!ok || last_n !== 40 || last_bits[39:0] !== fr || last_lb !== 1'b0) begin
      errors++;
      $display("FAIL midframe_change: n=%0d bits=%h lb=%b expected n=40 bits=%h lb=0", last_n, last_bits[39:0], last_lb, fr);
    end
  endtask

  task automatic test_reset_midframe();
    logic [39:0] fr;
    bit ok, seen;
    sel = 1'b0; miso_tie0 = 1'b0;
    fr = rand_frame();
    pulse_start(fr);
    seen = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      @(posedge clk); #1;
      if (cur_n >= 20) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL reset_mid_reach: bit 20 never reached, bits=%0d", cur_n); end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (obs_cs !== 1'b1 || obs_sclk !== 1'b0 || obs_mosi !== 1'b0 || obs_busy !== 1'b0 || obs_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_async: cs=%b sclk=%b mosi=%b busy=%b done=%b expected 1 0 0 0 0",
               obs_cs, obs_sclk, obs_mosi, obs_busy, obs_done);
    end
    @(negedge clk); #1;
    rst = 1'b1;
    fr = rand_frame();
    run_frame(fr, ok);
    checks++;
    if (!ok || last_n !== 40 || last_bits[39:0] !== fr || last_cs_low !== 324) begin
      errors++;
      $display("FAIL reset_mid_next: n=%0d bits=%h cs_low=%0d expected 40 %h 324", last_n, last_bits[39:0], last_cs_low, fr);
    end
  endtask

  task automatic test_back_to_back(input logic s);
    logic [39:0] fr;
    bit reached;
    int h, f0, d0, w0;
    sel = s; miso_tie0 = 1'b0;
    h = s ? 2 : 4;
    repeat (3) @(posedge clk);
    #1;
    fr = rand_frame();
    f0 = frames_seen; d0 = done_cnt; w0 = done_wide;
    clk_div_in = fr[31:0];
    duty_in    = fr[39:32];
    start      = 1'b1;
    reached    = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      if (frames_seen >= f0 + 2) begin
        reached = 1'b1;
        break;
      end
    end
    start = 1'b0;
    checks++;
    if (!reached) begin errors++; $display("FAIL b2b_h%0d_timeout: frames=%0d expected 2", h, frames_seen - f0); end
    checks++;
    if (last_gap !== h + 1) begin errors++; $display("FAIL b2b_h%0d_gap: got %0d expected %0d", h, last_gap, h + 1); end
    checks++;
    if (done_cnt - d0 !== 2 || done_wide !== w0) begin
      errors++;
      $display("FAIL b2b_h%0d_done: pulses=%0d wide=%0d expected 2 single-cycle pulses", h, done_cnt - d0, done_wide - w0);
    end
    checks++;
    if (last_n !== 40 || last_bits[39:0] !== fr || last_cs_low !== 81 * h || last_busy !== 82 * h) begin
      errors++;
      $display("FAIL b2b_h%0d_frame: n=%0d bits=%h cs_low=%0d busy=%0d expected 40 %h %0d %0d",
               h, last_n, last_bits[39:0], last_cs_low, last_busy, fr, 81 * h, 82 * h);
    end
    repeat (200) @(posedge clk);
    #1;
    checks++;
    if (frames_seen - f0 !== 2 || obs_busy !== 1'b0 || last_lb !== 1'b0) begin
      errors++;
      $display("FAIL b2b_h%0d_stop: frames=%0d busy=%b lb=%b expected 2 0 0", h, frames_seen - f0, obs_busy, last_lb);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    start = 1'b0; sel = 1'b0; miso_tie0 = 1'b0;
    clk_div_in = '0; duty_in = '0;
    #1 rst = 1'b0;
    test_reset();
    test_basic();
    test_loopback();
    test_busy_ignore();
    test_midframe_change();
    test_reset_midframe();
    test_back_to_back(1'b0);
    test_back_to_back(1'b1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
